lane_drain_scheduler: RTL and testbench

- Sequencer on the output side of the 16-lane buffering datapath.
- Captures one batch of up to 16 parallel 32-bit lane words, qualified by a per-lane valid mask.
- Drains the batch onto a single 32-bit stream with a valid/ready handshake, lowest lane index first.
- Reports the batch population and keeps a running count of completed batches for debug.

---
 rtl/lane_drain_scheduler.sv | 132 +++++++++++++
 tb/tb_lane_drain_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_drain_scheduler.sv
// rtl/lane_drain_scheduler.sv - captures a masked batch of lane words and drains it lowest lane first
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valids/in_data offered batch: per-lane valid mask and flattened lane words
//   in_ready          batch can be captured this cycle (IDLE)
//   out_data/out_lane presented word and its source lane
//   out_valid/out_ready/out_last  output stream handshake and end-of-batch flag
//   batch_size        popcount of the most recently captured mask
//   batch_count       number of fully drained batches (wraps)
module lane_drain_scheduler #(
  parameter int LANES = 16,
  parameter int WIDTH = 32,
  parameter int IDXW  = 4,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       in_valids,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDXW-1:0]        out_lane,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [IDXW:0]          batch_size,
  output logic [CNTW-1:0]        batch_count
);

  localparam int SW = IDXW + 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [LANES-1:0]       pending_q, pending_d;
  logic [LANES*WIDTH-1:0] data_q;
  logic [SW-1:0]          batch_size_q;
  logic [CNTW-1:0]        batch_count_q;

  logic                   capture;
  logic                   fire;
  logic                   batch_done;
  logic [IDXW-1:0]        sel_lane;
  logic [WIDTH-1:0]       sel_word;
  logic [LANES-1:0]       sel_onehot;
  logic [SW-1:0]          in_popcount;

  // Lowest set bit of pending wins: scan downward so the last hit is the lowest index.
  always_comb begin
    sel_lane = '0;
    sel_word = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_lane = IDXW'(i);
        sel_word = data_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // Isolate the lowest set bit (two's-complement trick).
  assign sel_onehot = pending_q & (~pending_q + LANES'(1));

  always_comb begin
    in_popcount = '0;
    for (int i = 0; i < LANES; i++) begin
      in_popcount = in_popcount + SW'(in_valids[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    capture    = 1'b0;
    fire       = 1'b0;
    batch_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (|in_valids) begin
          capture   = 1'b1;
          pending_d = in_valids;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          fire      = 1'b1;
          pending_d = pending_q & ~sel_onehot;
          if (pending_d == '0) begin
            batch_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      data_q        <= '0;
      batch_size_q  <= '0;
      batch_count_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (capture) begin
        data_q       <= in_data;
        batch_size_q <= in_popcount;
      end
      if (fire && batch_done) begin
        batch_count_q <= batch_count_q + CNTW'(1);
      end
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DRAIN);
  assign out_lane    = sel_lane;
  // Data forced to zero outside DRAIN so nothing stale is visible after reset or between batches.
  assign out_data    = out_valid ? sel_word : '0;
  // Exactly one bit left means the lowest set bit is the whole mask.
  assign out_last    = out_valid && (pending_q == sel_onehot);
  assign batch_size  = batch_size_q;
  assign batch_count = batch_count_q;

endmodule

// File: tb/tb_lane_drain_scheduler.sv
// tb/tb_lane_drain_scheduler.sv - scoreboard bench for lane_drain_scheduler
module tb_lane_drain_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  in_valids;
  logic [511:0] in_data;
  logic         out_ready;

  logic         in_ready;
  logic [31:0]  out_data;
  logic [3:0]   out_lane;
  logic         out_valid;
  logic         out_last;
  logic [4:0]   batch_size;
  logic [15:0]  batch_count;

  logic         in_ready2;
  logic [31:0]  out_data2;
  logic [3:0]   out_lane2;
  logic         out_valid2;
  logic         out_last2;
  logic [4:0]   batch_size2;
  logic [3:0]   batch_count2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  lane;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  lane_drain_scheduler dut (
    .clk(clk), .reset(reset), .in_valids(in_valids), .in_data(in_data),
    .in_ready(in_ready), .out_data(out_data), .out_lane(out_lane),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .batch_size(batch_size), .batch_count(batch_count)
  );

  // Narrow counter instance so the wrap from all-ones to zero is reachable quickly.
  lane_drain_scheduler #(.CNTW(4)) dut_wrap (
    .clk(clk), .reset(reset), .in_valids(in_valids), .in_data(in_data),
    .in_ready(in_ready2), .out_data(out_data2), .out_lane(out_lane2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_last(out_last2),
    .batch_size(batch_size2), .batch_count(batch_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: lane %0d data %h with nothing expected", out_lane, out_data);
        end else begin
          exp_t e;
          e = q[0];
          chk("sb_lane", 32'(out_lane), 32'(e.lane));
          chk("sb_data", out_data, e.data);
          chk("sb_last", 32'(out_last), 32'(e.last));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  endtask

  task automatic push_batch(input logic [15:0] mask, input logic [31:0] base);
    int hi;
    hi = 0;
    for (int k = 0; k < 16; k++) if (mask[k]) hi = k;
    for (int k = 0; k < 16; k++) begin
      if (mask[k]) q.push_back('{lane: 4'(k), data: base + 32'(k), last: (k == hi)});
    end
  endtask

  // Called at posedge+1; returns at capture edge +1.
  task automatic offer(input logic [15:0] mask, input logic [31:0] base, input bit toggle);
    in_valids = mask;
    for (int k = 0; k < 16; k++) in_data[k*32 +: 32] = base + 32'(k);
    push_batch(mask, base);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valids = '0;
    if (toggle) out_ready = 1'b0;
  endtask

  task automatic drain(input string tag, input bit toggle, input int exp_cycles,
                       input int exp_size, input int exp_count, input int exp_q);
    int  cyc;
    bit  done;
    cyc  = 0;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (!out_valid) begin
        done = 1'b1;
      end else begin
        cyc++;
        @(posedge clk);
        #1;
        if (toggle) out_ready = ~out_ready;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_batch_size"}, 32'(batch_size), 32'(exp_size));
    chk({tag, "_batch_count"}, 32'(batch_count), 32'(exp_count));
    chk({tag, "_sb_left"}, 32'(q.size()), 32'(exp_q));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  initial begin
    fork
      monitor();
    join_none

    reset     = 1'b1;
    in_valids = '0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_lane", 32'(out_lane), 32'd0);
    chk("rst_batch_size", 32'(batch_size), 32'd0);
    chk("rst_batch_count", 32'(batch_count), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-drain: lane 4 handshakes, then reset discards the rest.
    offer(16'h00F0, 32'h5000_0000, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_batch_count", 32'(batch_count), 32'd0);
    chk("mid_batch_size", 32'(batch_size), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    offer(16'h0001, 32'h6000_0000, 1'b0);
    drain("after_rst", 1'b0, 1, 1, 1, 0);

    // Sparse mask.
    offer(16'h8421, 32'hA000_0000, 1'b0);
    drain("sparse", 1'b0, 4, 4, 2, 0);

    // Full mask with alternating backpressure.
    offer(16'hFFFF, 32'h1234_0000, 1'b1);
    drain("full_bp", 1'b1, 32, 16, 3, 0);

    // Empty offers.
    for (int c = 0; c < 5; c++) begin
      in_valids = '0;
      in_data   = {16{$urandom()}};
      @(negedge clk);
      chk("empty_out_valid", 32'(out_valid), 32'd0);
      chk("empty_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("empty_batch_size", 32'(batch_size), 32'd16);

    // Input isolation: inputs change during DRAIN; new batch waits for the IDLE cycle.
    offer(16'h0003, 32'hB000_0000, 1'b0);
    in_valids = 16'hFFFF;
    for (int k = 0; k < 16; k++) in_data[k*32 +: 32] = 32'hC000_0000 + 32'(k);
    push_batch(16'hFFFF, 32'hC000_0000);
    drain("iso_first", 1'b0, 2, 2, 4, 16);
    in_valids = '0;
    drain("iso_second", 1'b0, 16, 16, 5, 0);

    // Counter wrap on the 4-bit instance.
    for (int b = 0; b < 10; b++) begin
      offer(16'h0001, 32'hD000_0000, 1'b0);
      drain("wrap_fill", 1'b0, 1, 1, 6 + b, 0);
    end
    chk("wrap_pre", 32'(batch_count2), 32'hF);
    offer(16'h0001, 32'hE000_0000, 1'b0);
    drain("wrap_last", 1'b0, 1, 1, 16, 0);
    chk("wrap_post", 32'(batch_count2), 32'h0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
